mem_nport_arbiter: RTL and testbench
====================================

Name: mem_nport_arbiter

Overview:
- Shared word-addressed memory model with NUM_PORTS independent requester ports: CPU, PCPI accelerators, DMA.
- Replaces the fixed two-port memory inside the simulation wrapper with one round-robin arbitrated port.
- Read latency is configurable; byte strobes apply on every port.
- Includes MMIO console and test-pass decode, plus sticky out-of-bounds error capture.
- Sits between the core/accelerators and the memory array in the wrapper.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..8)
- MEM_WORDS, 3145728, memory depth in 32-bit words
- LATENCY, 1, cycles from grant edge to rdy pulse (1..8)
- CONSOLE_ADDR, 32'h1000_0000, byte address for console character writes
- TEST_ADDR, 32'h2000_0000, byte address for test-result writes
- PASS_MAGIC, 32'd123456789, value written to TEST_ADDR that signals pass

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_addr  in  NUM_PORTS*32  per-port byte address; port p uses bits [32p+31:32p]
- req_wdata  in  NUM_PORTS*32  per-port write data
- req_wstrb  in  NUM_PORTS*4  per-port byte strobes; 0 means read
- req_ready  out  NUM_PORTS  per-port one-cycle completion pulse
- req_rdata  out  32  read data, valid while any req_ready bit is high
- console_valid  out  1  one-cycle pulse on a console write
- console_data  out  8  character; valid with console_valid
- tests_passed  out  1  sticky pass flag
- oob_err  out  1  sticky out-of-bounds write flag
- oob_addr  out  32  address of the first out-of-bounds write

Behaviour:
- Reset (async, resetn=0): all outputs 0, FSM=IDLE, rr pointer=0, latency counter=0. Memory contents are not reset. Reset asserted mid-transaction aborts it; no rdy is issued and a pending write may or may not have committed.
- FSM IDLE:
  - If any req_valid is set, grant the first set bit at or after the rr pointer, cyclically.
  - Latch port id, addr, wdata, wstrb. Set counter=LATENCY-1. Go to BUSY.
- The access is performed on the grant edge:
  - Writes commit byte-wise per wstrb to memory[addr>>2] when (addr>>2) < MEM_WORDS.
  - Reads sample memory[addr>>2] into a holding register.
- FSM BUSY: counter decrements each cycle. At counter==0, assert req_ready[granted] for one cycle, drive req_rdata, and return to IDLE. The rr pointer becomes granted+1 mod NUM_PORTS.
- LATENCY=1 gives rdy in the cycle immediately after the grant edge.
- Sustained throughput is one transaction per LATENCY+1 cycles.
- IDLE ignores req_valid on the port whose rdy is high in the same cycle. A requester may hold valid into the next transaction; a held valid is re-arbitrated normally.
- Requesters hold valid/addr/wdata/wstrb stable until rdy. Changes after grant are ignored.
- Reads:
  - Out-of-range or MMIO reads return 32'h0 and complete normally.
  - req_rdata is 0 outside rdy cycles.
- Writes to CONSOLE_ADDR: console_valid pulses together with rdy, console_data=wdata[7:0]. Memory is untouched.
- Writes to TEST_ADDR: if wdata==PASS_MAGIC, set tests_passed (sticky until reset). Other values are ignored.
- Any other out-of-range write:
  - Completes with rdy (the block never hangs) and sets oob_err.
  - oob_addr captures only the first offending address.
- Address decode priority: in-range memory, then CONSOLE_ADDR, then TEST_ADDR, then OOB.
- Unaligned addresses: the low 2 bits are ignored for memory; MMIO matches require exact equality.
- NUM_PORTS=1: the arbiter degenerates to a pass-through; the pointer stays 0.

Decomposition:
- Shared package mem_pkg holds:
  - CONSOLE_ADDR, TEST_ADDR and PASS_MAGIC defaults
  - FSM state enum {IDLE, BUSY}
  - port-id width function clog2(NUM_PORTS)
- One sub-module, rr_arbiter:
  - Parameter N; inputs req[N], ptr; outputs grant_onehot and grant_idx.
  - Purely combinational priority rotate.
- The pointer register lives in the parent.

Test Plan:
- Single port, LATENCY=1: write 0xDEADBEEF to 0x100 with wstrb=4'hF, then read 0x100. Write rdy arrives 1 cycle after grant; read returns 0xDEADBEEF.
- Byte strobes: word 0x100 holds 0xDEADBEEF; write 0x000000AA with wstrb=4'b0001. A read of 0x100 returns 0xDEADBEAA.
- Contention, NUM_PORTS=3, LATENCY=2, all valids held high: grants go 0,1,2,0,1,2. Each rdy is a single-cycle pulse spaced 3 cycles apart.
- MMIO:
  - Write 0x41 to 0x1000_0000: console_valid=1 for one cycle with console_data=8'h41.
  - Write 123456789 to 0x2000_0000: tests_passed=1.
  - Write 5 to 0x2000_0000 first: tests_passed stays 0.
- OOB: write to 0x3000_0000, then to 0x3000_0004. rdy is given each time; oob_err=1 and oob_addr=0x3000_0000. An OOB read returns 0.
- Reset mid-BUSY with LATENCY=4: drop resetn 2 cycles after the grant. No rdy is issued and all outputs go to 0 immediately. After release, a fresh request to port 0 is granted first.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the N-port arbitrated memory model: MMIO defaults,
// FSM state encoding and the port-id width helper.
package mem_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;
  localparam logic [31:0] TEST_ADDR_DEF    = 32'h2000_0000;
  localparam logic [31:0] PASS_MAGIC_DEF   = 32'd123456789;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Bits needed to hold a port index; never less than one so a
  // single-port build still has a legal vector width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(n)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting index at
// or after ptr, wrapping cyclically. The pointer itself lives in the parent.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx
);

  logic found_s;
  int   cand_s;

  // Scan N candidates starting at ptr and keep the first one requesting.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found_s      = 1'b0;
    cand_s       = 0;
    for (int k = 0; k < N; k++) begin
      cand_s = (int'(ptr) + k) % N;
      if (!found_s && req[cand_s]) begin
        found_s              = 1'b1;
        grant_onehot[cand_s] = 1'b1;
        grant_idx            = IW'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mem_nport_arbiter.sv
// Shared word-addressed memory with NUM_PORTS round-robin arbitrated
// requesters, configurable read latency, MMIO console / test-pass decode and
// sticky capture of the first out-of-bounds write.
module mem_nport_arbiter
  import mem_pkg::*;
#(
  parameter int          NUM_PORTS    = 2,
  parameter int          MEM_WORDS    = 3145728,
  parameter int          LATENCY      = 1,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter logic [31:0] TEST_ADDR    = TEST_ADDR_DEF,
  parameter logic [31:0] PASS_MAGIC   = PASS_MAGIC_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_PORTS-1:0]    req_valid,
  input  logic [NUM_PORTS*32-1:0] req_addr,
  input  logic [NUM_PORTS*32-1:0] req_wdata,
  input  logic [NUM_PORTS*4-1:0]  req_wstrb,
  output logic [NUM_PORTS-1:0]    req_ready,
  output logic [31:0]             req_rdata,
  output logic                    console_valid,
  output logic [7:0]              console_data,
  output logic                    tests_passed,
  output logic                    oob_err,
  output logic [31:0]             oob_addr
);

  localparam int         IW     = clog2(NUM_PORTS);
  localparam int         AW     = $clog2(MEM_WORDS);
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  logic [31:0] mem_q [MEM_WORDS];

  state_e                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         id_q, id_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           hold_q, hold_d;
  logic                  con_q, con_d;
  logic [7:0]            con_char_q, con_char_d;
  logic [NUM_PORTS-1:0]  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  con_valid_q, con_valid_d;
  logic [7:0]            con_data_q, con_data_d;
  logic                  passed_q, passed_d;
  logic                  oob_q, oob_d;
  logic [31:0]           oob_addr_q, oob_addr_d;

  logic [NUM_PORTS-1:0]  req_masked_s;
  logic [NUM_PORTS-1:0]  gnt_oh_s;
  logic [IW-1:0]         gnt_idx_s;
  logic                  grant_s;
  logic [31:0]           sel_addr_s, sel_wdata_s;
  logic [3:0]            sel_wstrb_s;
  logic [31:0]           word_s;
  logic [AW-1:0]         mem_idx_s;
  logic                  in_range_s, is_wr_s, is_con_s, is_test_s;
  logic [31:0]           rd_word_s;
  logic                  fire_s;
  logic [IW-1:0]         fire_id_s;

  // A port whose completion pulse is showing must not be re-granted in the same cycle.
  assign req_masked_s = req_valid & ~ready_q;

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_rr (
    .req          (req_masked_s),
    .ptr          (ptr_q),
    .grant_onehot (gnt_oh_s),
    .grant_idx    (gnt_idx_s)
  );

  assign grant_s = (state_q == IDLE) && (|gnt_oh_s);

  // AND-OR mux of the granted requester's address, data and strobes.
  always_comb begin
    sel_addr_s  = 32'h0;
    sel_wdata_s = 32'h0;
    sel_wstrb_s = 4'h0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_oh_s[p]) begin
        sel_addr_s  = req_addr[32*p +: 32];
        sel_wdata_s = req_wdata[32*p +: 32];
        sel_wstrb_s = req_wstrb[4*p +: 4];
      end else begin
        sel_addr_s  = sel_addr_s;
      end
    end
  end

  // Address decode: memory wins, then console, then test register; low bits ignored only for memory.
  always_comb begin
    word_s     = {2'b00, sel_addr_s[31:2]};
    mem_idx_s  = sel_addr_s[AW+1:2];
    in_range_s = (word_s < 32'(MEM_WORDS));
    is_wr_s    = (sel_wstrb_s != 4'h0);
    is_con_s   = !in_range_s && (sel_addr_s == CONSOLE_ADDR);
    is_test_s  = !in_range_s && !is_con_s && (sel_addr_s == TEST_ADDR);
    if (in_range_s && !is_wr_s) begin
      rd_word_s = mem_q[mem_idx_s];
    end else begin
      rd_word_s = 32'h0;
    end
  end

  // Byte-strobed memory write on the grant edge; the array is never reset.
  always_ff @(posedge clk) begin
    if (grant_s && is_wr_s && in_range_s) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_wstrb_s[b]) begin
          mem_q[mem_idx_s][8*b +: 8] <= sel_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Completion is launched from the grant edge when LATENCY is 1, otherwise one cycle before the counter empties.
  always_comb begin
    fire_s    = (grant_s && (LAT_M1 == 3'd0)) ||
                ((state_q == BUSY) && (cnt_q == 3'd1));
    fire_id_s = grant_s ? gnt_idx_s : id_q;
  end

  // Next-state logic for the FSM, pointer, transaction latches and outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    con_d       = con_q;
    con_char_d  = con_char_q;
    passed_d    = passed_q;
    oob_d       = oob_q;
    oob_addr_d  = oob_addr_q;

    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d    = BUSY;
          id_d       = gnt_idx_s;
          cnt_d      = LAT_M1;
          hold_d     = rd_word_s;
          con_d      = is_wr_s && is_con_s;
          con_char_d = sel_wdata_s[7:0];
          if (is_wr_s && is_test_s && (sel_wdata_s == PASS_MAGIC)) begin
            passed_d = 1'b1;
          end else begin
            passed_d = passed_q;
          end
          if (is_wr_s && !in_range_s && !is_con_s && !is_test_s && !oob_q) begin
            oob_d      = 1'b1;
            oob_addr_d = sel_addr_s;
          end else begin
            oob_d      = oob_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
          ptr_d   = (id_q == IW'(NUM_PORTS - 1)) ? '0 : id_q + IW'(1);
        end else begin
          cnt_d   = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    for (int p = 0; p < NUM_PORTS; p++) begin
      ready_d[p] = fire_s && (fire_id_s == IW'(p));
    end
    if (fire_s) begin
      rdata_d     = grant_s ? rd_word_s : hold_q;
      con_valid_d = grant_s ? (is_wr_s && is_con_s) : con_q;
      con_data_d  = (grant_s ? (is_wr_s && is_con_s) : con_q) ?
                    (grant_s ? sel_wdata_s[7:0] : con_char_q) : con_data_q;
    end else begin
      rdata_d     = 32'h0;
      con_valid_d = 1'b0;
      con_data_d  = con_data_q;
    end
  end

  // State and output registers; asynchronous reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= 3'd0;
      hold_q      <= 32'h0;
      con_q       <= 1'b0;
      con_char_q  <= 8'h0;
      ready_q     <= '0;
      rdata_q     <= 32'h0;
      con_valid_q <= 1'b0;
      con_data_q  <= 8'h0;
      passed_q    <= 1'b0;
      oob_q       <= 1'b0;
      oob_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      con_q       <= con_d;
      con_char_q  <= con_char_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      con_valid_q <= con_valid_d;
      con_data_q  <= con_data_d;
      passed_q    <= passed_d;
      oob_q       <= oob_d;
      oob_addr_q  <= oob_addr_d;
    end
  end

  assign req_ready     = ready_q;
  assign req_rdata     = rdata_q;
  assign console_valid = con_valid_q;
  assign console_data  = con_data_q;
  assign tests_passed  = passed_q;
  assign oob_err       = oob_q;
  assign oob_addr      = oob_addr_q;

endmodule

// File: tb/tb_mem_nport_arbiter.sv
// Directed bench for mem_nport_arbiter: three configurations (1 port/LAT 1,
// 3 ports/LAT 2, 2 ports/LAT 4) exercised with hand-computed expectations.
module tb_mem_nport_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- instance A: 1 port, LATENCY 1 ----------------
  logic        a_rstn;
  logic [0:0]  a_valid, a_ready;
  logic [31:0] a_addr, a_wdata, a_rdata, a_oa;
  logic [3:0]  a_wstrb;
  logic        a_cv, a_tp, a_oe;
  logic [7:0]  a_cd;

  mem_nport_arbiter #(.NUM_PORTS(1), .MEM_WORDS(1024), .LATENCY(1)) dut_a (
    .clk(clk), .resetn(a_rstn), .req_valid(a_valid), .req_addr(a_addr),
    .req_wdata(a_wdata), .req_wstrb(a_wstrb), .req_ready(a_ready),
    .req_rdata(a_rdata), .console_valid(a_cv), .console_data(a_cd),
    .tests_passed(a_tp), .oob_err(a_oe), .oob_addr(a_oa));

  // ---------------- instance B: 3 ports, LATENCY 2 ----------------
  logic        b_rstn;
  logic [2:0]  b_valid, b_ready;
  logic [95:0] b_addr, b_wdata;
  logic [11:0] b_wstrb;
  logic [31:0] b_rdata, b_oa;
  logic        b_cv, b_tp, b_oe;
  logic [7:0]  b_cd;

  mem_nport_arbiter #(.NUM_PORTS(3), .MEM_WORDS(256), .LATENCY(2)) dut_b (
    .clk(clk), .resetn(b_rstn), .req_valid(b_valid), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_wstrb(b_wstrb), .req_ready(b_ready),
    .req_rdata(b_rdata), .console_valid(b_cv), .console_data(b_cd),
    .tests_passed(b_tp), .oob_err(b_oe), .oob_addr(b_oa));

  // ---------------- instance C: 2 ports, LATENCY 4 ----------------
  logic        c_rstn;
  logic [1:0]  c_valid, c_ready;
  logic [63:0] c_addr, c_wdata;
  logic [7:0]  c_wstrb;
  logic [31:0] c_rdata, c_oa;
  logic        c_cv, c_tp, c_oe;
  logic [7:0]  c_cd;

  mem_nport_arbiter #(.NUM_PORTS(2), .MEM_WORDS(256), .LATENCY(4)) dut_c (
    .clk(clk), .resetn(c_rstn), .req_valid(c_valid), .req_addr(c_addr),
    .req_wdata(c_wdata), .req_wstrb(c_wstrb), .req_ready(c_ready),
    .req_rdata(c_rdata), .console_valid(c_cv), .console_data(c_cd),
    .tests_passed(c_tp), .oob_err(c_oe), .oob_addr(c_oa));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on instance A; returns data/console seen at the rdy cycle.
  task automatic txn_a(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rdata,
                       output int cyc, output logic cv, output logic [7:0] cd);
    @(negedge clk);
    a_valid = 1'b1; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (a_ready == 1'b0 && cyc < 20);
    rdata = a_rdata; cv = a_cv; cd = a_cd;
    a_valid = 1'b0;
  endtask

  logic [31:0] rd;
  logic        cv;
  logic [7:0]  cd;
  int          cyc;
  logic [2:0]  exp_b;

  initial begin
    a_rstn = 1'b0; b_rstn = 1'b0; c_rstn = 1'b0;
    a_valid = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    b_valid = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
    c_valid = '0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
    repeat (3) @(negedge clk);
    a_rstn = 1'b1; b_rstn = 1'b1; c_rstn = 1'b1;
    @(negedge clk);

    // ---- reset state ----
    chk("rst_ready",  32'(a_ready), 32'h0);
    chk("rst_rdata",  a_rdata, 32'h0);
    chk("rst_flags",  {29'h0, a_cv, a_tp, a_oe}, 32'h0);
    chk("rst_oobaddr", a_oa, 32'h0);
    chk("rst_cdata",  32'(a_cd), 32'h0);

    // ---- basic write/read, LATENCY 1 ----
    txn_a(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, rd, cyc, cv, cd);
    chk("wr_latency", 32'(cyc), 32'd1);
    chk("wr_rdata_zero", rd, 32'h0);
    txn_a(32'h0000_0100, 32'h0, 4'h0, rd, cyc, cv, cd);
    chk("rd_latency", 32'(cyc), 32'd1);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rdy_single_pulse", 32'(a_ready), 32'h0);
    chk("rdata_idle_zero", a_rdata, 32'h0);

    // ---- byte strobes and unaligned read ----
    txn_a(32'h0000_0100, 32'h0000_00AA, 4'b0001, rd, cyc, cv, cd);
    txn_a(32'h0000_0103, 32'h0, 4'h0, rd, cyc, cv, cd);
    chk("strobe_rd", rd, 32'hDEAD_BEAA);

    // ---- last in-range word and first out-of-range word ----
    txn_a(32'h0000_0FFC, 32'h1234_5678, 4'hF, rd, cyc, cv, cd);
    txn_a(32'h0000_0FFC, 32'h0, 4'h0, rd, cyc, cv, cd);
    chk("last_word_rd", rd, 32'h1234_5678);
    txn_a(32'h0000_1000, 32'h0, 4'h0, rd, cyc, cv, cd);
    chk("past_end_rd", rd, 32'h0);

    // ---- MMIO ----
    txn_a(32'h2000_0000, 32'd5, 4'hF, rd, cyc, cv, cd);
    chk("test_wrong_val", 32'(a_tp), 32'h0);
    chk("test_no_oob", 32'(a_oe), 32'h0);
    txn_a(32'h1000_0000, 32'h0000_0041, 4'hF, rd, cyc, cv, cd);
    chk("con_valid", 32'(cv), 32'h1);
    chk("con_data", 32'(cd), 32'h41);
    @(negedge clk);
    chk("con_valid_pulse", 32'(a_cv), 32'h0);
    txn_a(32'h2000_0000, 32'd123456789, 4'hF, rd, cyc, cv, cd);
    chk("test_pass", 32'(a_tp), 32'h1);
    chk("console_not_oob", 32'(a_oe), 32'h0);

    // ---- out of bounds ----
    txn_a(32'h3000_0000, 32'h1, 4'hF, rd, cyc, cv, cd);
    chk("oob_wr_rdy", 32'(cyc), 32'd1);
    chk("oob_err", 32'(a_oe), 32'h1);
    chk("oob_addr", a_oa, 32'h3000_0000);
    txn_a(32'h3000_0004, 32'h2, 4'hF, rd, cyc, cv, cd);
    chk("oob_addr_first", a_oa, 32'h3000_0000);
    txn_a(32'h3000_0000, 32'h0, 4'h0, rd, cyc, cv, cd);
    chk("oob_rd_zero", rd, 32'h0);
    txn_a(32'h1000_0000, 32'h0, 4'h0, rd, cyc, cv, cd);
    chk("mmio_rd_zero", rd, 32'h0);
    chk("mmio_rd_no_con", 32'(cv), 32'h0);
    chk("tests_sticky", 32'(a_tp), 32'h1);

    // ---- contention: 3 ports, LATENCY 2, all valids held ----
    @(negedge clk);
    b_valid = 3'b111;
    b_addr  = {32'h0000_0008, 32'h0000_0004, 32'h0000_0000};
    b_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    b_wstrb = 12'hFFF;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      exp_b = (i % 3 == 2) ? (3'b001 << (((i - 2) / 3) % 3)) : 3'b000;
      chk($sformatf("rr_ready_%0d", i), 32'(b_ready), 32'(exp_b));
    end
    b_valid = 3'b000;

    // ---- instance C: complete a pass write on port 0 (ptr moves to 1) ----
    @(negedge clk);
    c_valid = 2'b01;
    c_addr  = {32'h0, 32'h2000_0000};
    c_wdata = {32'h0, 32'd123456789};
    c_wstrb = 8'h0F;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (c_ready == 2'b00 && cyc < 20);
    chk("lat4_cycles", 32'(cyc), 32'd4);
    chk("lat4_port", 32'(c_ready), 32'h1);
    c_valid = 2'b00;
    @(negedge clk);
    chk("c_pass", 32'(c_tp), 32'h1);

    // ---- grant port 1, then reset two cycles into BUSY ----
    c_valid = 2'b10;
    c_addr  = {32'h0000_0020, 32'h0};
    c_wdata = {32'h0000_0001, 32'h0};
    c_wstrb = 8'hF0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 c_rstn = 1'b0;
    #1;
    chk("abort_ready", 32'(c_ready), 32'h0);
    chk("abort_pass_clr", 32'(c_tp), 32'h0);
    chk("abort_rdata", c_rdata, 32'h0);
    c_valid = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rdy", 32'(c_ready), 32'h0);
    end

    // ---- release with both ports requesting: port 0 must win ----
    c_valid = 2'b11;
    c_addr  = {32'h0000_0034, 32'h0000_0030};
    c_wdata = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
    c_wstrb = 8'hFF;
    c_rstn  = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (c_ready == 2'b00 && cyc < 20);
    chk("post_rst_cycles", 32'(cyc), 32'd4);
    chk("post_rst_port0", 32'(c_ready), 32'h1);
    c_valid = 2'b00;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
